// File: rtl/nibble_serial_arith_ctrl.sv
// Nibble-serial two's-complement add/subtract sequencer. One shared 4-bit slice
// handles a W = 4*NIB bit operation in NIB cycles, LSB nibble first.
module nibble_serial_arith_ctrl #(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB,
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         cout,
    output logic         ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    part_q;
    logic [W-1:0]    z_q;
    logic            cout_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;

    // Shared slice: operates on nibble idx_q of the latched operands.
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      bm;
    logic [4:0]      sum5;
    logic [W-1:0]    part_d;
    logic            last_nib;
    logic            ovf_d;

    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        a_nib    = a_q[{idx_q, 2'b00} +: 4];
        b_nib    = b_q[{idx_q, 2'b00} +: 4];
        bm       = op_q ? ~b_nib : b_nib;
        sum5     = {1'b0, a_nib} + {1'b0, bm} + {4'b0000, carry_q};
        part_d   = part_q;
        part_d[{idx_q, 2'b00} +: 4] = sum5[3:0];
        last_nib = (idx_q == IW'(NIB - 1));
        // Operand signs agree but the result sign differs: only meaningful on
        // the top nibble, where a_nib[3] and bm[3] are the effective signs.
        ovf_d    = (a_nib[3] == bm[3]) && (sum5[3] != a_nib[3]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the operand and partial registers are reset too; they are a
    // handful of flops, not a memory array, and a clean reset state keeps
    // an aborted operation from leaking stale nibbles into later results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= op;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    part_q  <= part_d;
                    carry_q <= sum5[4];
                    if (last_nib) begin
                        z_q     <= part_d;
                        cout_q  <= sum5[4];
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_arith_ctrl.sv
// Directed self-checking bench for nibble_serial_arith_ctrl at NIB = 4, 1 and 8.
module tb_nibble_serial_arith_ctrl;

    logic clk;
    logic rst_n;

    // NIB = 4 instance
    logic        start4, op4, busy4, done4, cout4, ovf4;
    logic [15:0] a4, b4, z4;
    // NIB = 1 instance
    logic        start1, op1, busy1, done1, cout1, ovf1;
    logic [3:0]  a1, b1, z1;
    // NIB = 8 instance
    logic        start8, op8, busy8, done8, cout8, ovf8;
    logic [31:0] a8, b8, z8;

    int checks = 0;
    int errors = 0;

    nibble_serial_arith_ctrl #(.NIB(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .z(z4), .cout(cout4), .ovf(ovf4)
    );

    nibble_serial_arith_ctrl #(.NIB(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .z(z1), .cout(cout1), .ovf(ovf1)
    );

    nibble_serial_arith_ctrl #(.NIB(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .z(z8), .cout(cout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while u_dut4 is idle; returns at the negedge of the
    // first IDLE cycle after done, so consecutive calls are back-to-back.
    // Optionally pulses a junk start at loop step 'poke_at' while busy.
    task automatic run4(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic opv, input int poke_at,
                        input logic [15:0] ez, input logic ec, input logic ev);
        int n;
        int busy_cnt;
        int done_cnt;
        logic [15:0] prev_z;
        prev_z = z4;
        start4 = 1'b1; a4 = av; b4 = bv; op4 = opv;
        @(negedge clk);
        start4 = 1'b0;
        a4 = ~av; b4 = ~bv; op4 = ~opv;
        n = 0;
        busy_cnt = busy4 ? 1 : 0;
        done_cnt = 0;
        while (!done4 && n < 40) begin
            if (n == poke_at) begin
                start4 = 1'b1; a4 = 16'hAAAA; b4 = 16'h5555; op4 = 1'b1;
            end
            @(negedge clk);
            start4 = 1'b0;
            n++;
            if (n == 1) check({tag, " z_hold"}, 64'(z4), 64'(prev_z));
            if (busy4) busy_cnt++;
            if (done4) done_cnt++;
        end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " z"}, 64'(z4), 64'(ez));
        check({tag, " cout"}, 64'(cout4), 64'(ec));
        check({tag, " ovf"}, 64'(ovf4), 64'(ev));
        @(negedge clk);
        if (done4) done_cnt++;
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd5);
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " idle"}, 64'(busy4), 64'd0);
        check({tag, " z_after"}, 64'(z4), 64'(ez));
    endtask

    initial begin
        logic [32:0] ref_sum;
        logic [31:0] ra, rb, rz;
        logic        rop, rc, rv;
        int          n;
        int          done_seen;

        rst_n = 1'b0;
        start4 = 0; op4 = 0; a4 = '0; b4 = '0;
        start1 = 0; op1 = 0; a1 = '0; b1 = '0;
        start8 = 0; op8 = 0; a8 = '0; b8 = '0;
        #2;
        check("reset z", 64'(z4), 64'd0);
        check("reset busy", 64'(busy4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        check("reset cout_ovf", 64'({cout4, ovf4}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run4("add",      16'h1234, 16'h0FF1, 1'b0, -1, 16'h2225, 1'b0, 1'b0);
        run4("add_wrap", 16'hFFFF, 16'h0001, 1'b0, -1, 16'h0000, 1'b1, 1'b0);
        run4("add_ovf",  16'h7FFF, 16'h0001, 1'b0, -1, 16'h8000, 1'b0, 1'b1);
        run4("sub_neg",  16'h0005, 16'h0007, 1'b1, -1, 16'hFFFE, 1'b0, 1'b0);
        run4("sub_ovf",  16'h8000, 16'h0001, 1'b1, -1, 16'h7FFF, 1'b1, 1'b1);
        run4("ignored",  16'h1111, 16'h2222, 1'b0,  2, 16'h3333, 1'b0, 1'b0);
        run4("b2b",      16'h00F0, 16'h0010, 1'b1, -1, 16'h00E0, 1'b1, 1'b0);

        // Abort during RUN index 2: outputs clear asynchronously, no done.
        start4 = 1'b1; a4 = 16'h4321; b4 = 16'h1111; op4 = 1'b0;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid busy", 64'(busy4), 64'd0);
        check("rst_mid z", 64'(z4), 64'd0);
        check("rst_mid cout_ovf_done", 64'({cout4, ovf4, done4}), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done4) done_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4 || busy4) done_seen++;
        end
        check("rst_mid no_done", 64'(done_seen), 64'd0);
        run4("after_rst", 16'h4321, 16'h1111, 1'b0, -1, 16'h5432, 1'b0, 1'b0);

        // NIB = 1: 0x9 + 0x9 = 0x12
        start1 = 1'b1; a1 = 4'h9; b1 = 4'h9; op1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("nib1 latency", 64'(n), 64'd1);
        check("nib1 z", 64'(z1), 64'h2);
        check("nib1 cout_ovf", 64'({cout1, ovf1}), 64'b11);
        @(negedge clk);
        check("nib1 idle", 64'(busy1), 64'd0);

        // NIB = 8 against a W-bit reference model
        for (int t = 0; t < 8; t++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 1'($urandom_range(1, 0));
            if (t == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h0000_0001; rop = 1'b0; end
            if (t == 1) begin ra = 32'h8000_0000; rb = 32'h0000_0001; rop = 1'b1; end
            if (rop) begin
                rz = ra - rb;
                rc = (ra >= rb);
                rv = (ra[31] != rb[31]) && (rz[31] != ra[31]);
            end else begin
                ref_sum = {1'b0, ra} + {1'b0, rb};
                rz = ref_sum[31:0];
                rc = ref_sum[32];
                rv = (ra[31] == rb[31]) && (rz[31] != ra[31]);
            end
            start8 = 1'b1; a8 = ra; b8 = rb; op8 = rop;
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (!done8 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("nib8 latency", 64'(n), 64'd8);
            check("nib8 z", 64'(z8), 64'(rz));
            check("nib8 cout_ovf", 64'({cout8, ovf8}), 64'({rc, rv}));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
